// File: rtl/tmds_pkg.sv
// Shared TMDS symbol constants and types for the receive-side channel decoder.
package tmds_pkg;

  localparam int unsigned SYM_W = 10;

  // Control-period tokens, bits 9..0, indexed by {c1,c0}
  localparam logic [SYM_W-1:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_11 = 10'b1010101011;

  // Guard-band symbols
  localparam logic [SYM_W-1:0] GUARD_TOK_A = 10'b1011001100;
  localparam logic [SYM_W-1:0] GUARD_TOK_B = 10'b0100110011;

  // TERC4 code words, index = decoded nibble
  localparam logic [SYM_W-1:0] TERC4_CODES [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef enum logic [1:0] {
    SYM_DATA  = 2'd0,
    SYM_CTRL  = 2'd1,
    SYM_TERC4 = 2'd2,
    SYM_GUARD = 2'd3
  } sym_type_t;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational classification and decode of one aligned 10-bit TMDS symbol.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] word,
  output sym_type_t        sym_type_c,
  output logic [7:0]       data_c,
  output logic [1:0]       ctrl_c,
  output logic [3:0]       terc4_c
);

  logic [7:0] q;
  logic [7:0] dec;
  logic       terc_hit;
  logic [3:0] terc_nib;

  // Priority CTRL > GUARD > TERC4 > DATA; unused fields stay zero
  always_comb begin
    sym_type_c = SYM_DATA;
    data_c     = '0;
    ctrl_c     = '0;
    terc4_c    = '0;
    terc_hit   = 1'b0;
    terc_nib   = '0;
    dec        = '0;

    q = word[9] ? ~word[7:0] : word[7:0];
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    for (int i = 0; i < 16; i++) begin
      if (word == TERC4_CODES[i]) begin
        terc_hit = 1'b1;
        terc_nib = 4'(i);
      end
    end

    if (word == CTRL_TOK_00) begin
      sym_type_c = SYM_CTRL;
      ctrl_c     = 2'b00;
    end else if (word == CTRL_TOK_01) begin
      sym_type_c = SYM_CTRL;
      ctrl_c     = 2'b01;
    end else if (word == CTRL_TOK_10) begin
      sym_type_c = SYM_CTRL;
      ctrl_c     = 2'b10;
    end else if (word == CTRL_TOK_11) begin
      sym_type_c = SYM_CTRL;
      ctrl_c     = 2'b11;
    end else if (word == GUARD_TOK_A || word == GUARD_TOK_B) begin
      sym_type_c = SYM_GUARD;
    end else if (terc_hit) begin
      sym_type_c = SYM_TERC4;
      terc4_c    = terc_nib;
    end else begin
      sym_type_c = SYM_DATA;
      data_c     = dec;
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel receiver: bit-slip alignment on control-token runs plus symbol decode.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned SEARCH_WINDOW = 2048,
  parameter int unsigned LOSS_TIMEOUT  = 4096
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             raw_valid,
  input  logic [SYM_W-1:0] raw_word,
  output logic             locked,
  output logic [3:0]       bit_offset,
  output logic             sym_valid,
  output logic [1:0]       sym_type,
  output logic [7:0]       data,
  output logic [1:0]       ctrl,
  output logic [3:0]       terc4,
  output logic [7:0]       slip_count
);

  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WIN_W  = $clog2(SEARCH_WINDOW);
  localparam int unsigned LOSS_W = $clog2(LOSS_TIMEOUT);
  localparam int unsigned WND_W  = 2 * SYM_W;

  logic [SYM_W-1:0]  prev_word;
  logic [SYM_W-1:0]  s1_word;
  logic              s1_valid;
  logic [WND_W-1:0]  window_c;
  logic [SYM_W-1:0]  aligned_c;

  sym_type_t         dec_type_c;
  logic [7:0]        dec_data_c;
  logic [1:0]        dec_ctrl_c;
  logic [3:0]        dec_terc4_c;

  align_state_t      state_q;
  align_state_t      state_nxt;
  logic [RUN_W-1:0]  run_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [LOSS_W-1:0] loss_cnt;
  logic              flush_q;

  logic              run_inc_c;
  logic              lock_hit_c;
  logic              slip_hit_c;
  logic              loss_hit_c;

  // Earliest bit sits at bit 0, so older word occupies the low half of the window
  assign window_c  = {raw_word, prev_word};
  assign aligned_c = SYM_W'(window_c >> bit_offset);

  // Stage 1: history word and aligned symbol; idle cycles hold everything
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      prev_word <= '0;
      s1_word   <= '0;
      s1_valid  <= 1'b0;
    end else begin
      s1_valid <= raw_valid;
      if (raw_valid) begin
        prev_word <= raw_word;
        s1_word   <= aligned_c;
      end
    end
  end

  tmds_symbol_decode u_decode (
    .word       (s1_word),
    .sym_type_c (dec_type_c),
    .data_c     (dec_data_c),
    .ctrl_c     (dec_ctrl_c),
    .terc4_c    (dec_terc4_c)
  );

  // Alignment state register
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state: lock on a full token run, fall back on a long token drought
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_SEARCH: if (lock_hit_c) state_nxt = ST_LOCKED;
      ST_LOCKED: if (loss_hit_c) state_nxt = ST_SEARCH;
    endcase
  end

  // Event strobes; lock outranks a slip landing on the same symbol
  always_comb begin
    run_inc_c  = 1'b0;
    lock_hit_c = 1'b0;
    slip_hit_c = 1'b0;
    loss_hit_c = 1'b0;
    if (s1_valid) begin
      if (state_q == ST_SEARCH) begin
        run_inc_c  = (dec_type_c == SYM_CTRL) && !flush_q;
        lock_hit_c = run_inc_c && (run_cnt == RUN_W'(LOCK_COUNT - 1));
        slip_hit_c = !lock_hit_c && (win_cnt == WIN_W'(SEARCH_WINDOW - 1));
      end else begin
        loss_hit_c = (dec_type_c != SYM_CTRL) &&
                     (loss_cnt == LOSS_W'(LOSS_TIMEOUT - 1));
      end
    end
  end

  // Run/window/loss counters, slip offset and slip statistics
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt    <= '0;
      win_cnt    <= '0;
      loss_cnt   <= '0;
      flush_q    <= 1'b0;
      bit_offset <= '0;
      slip_count <= '0;
    end else if (s1_valid) begin
      if (state_q == ST_SEARCH) begin
        if (lock_hit_c) begin
          run_cnt  <= '0;
          win_cnt  <= '0;
          loss_cnt <= '0;
          flush_q  <= 1'b0;
        end else if (slip_hit_c) begin
          run_cnt    <= '0;
          win_cnt    <= '0;
          flush_q    <= 1'b1;
          bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
          if (slip_count != 8'hFF) slip_count <= slip_count + 8'd1;
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          flush_q <= 1'b0;
          // The symbol right after a slip was aligned with the old offset
          if (!flush_q) run_cnt <= run_inc_c ? run_cnt + RUN_W'(1) : '0;
        end
      end else begin
        if (loss_hit_c) begin
          run_cnt  <= '0;
          win_cnt  <= '0;
          loss_cnt <= '0;
          flush_q  <= 1'b0;
        end else if (dec_type_c == SYM_CTRL) begin
          loss_cnt <= '0;
        end else begin
          loss_cnt <= loss_cnt + LOSS_W'(1);
        end
      end
    end
  end

  // Stage 2: registered decode; valid only qualified while locked
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      sym_type  <= '0;
      data      <= '0;
      ctrl      <= '0;
      terc4     <= '0;
      sym_valid <= 1'b0;
      locked    <= 1'b0;
    end else begin
      sym_type  <= dec_type_c;
      data      <= dec_data_c;
      ctrl      <= dec_ctrl_c;
      terc4     <= dec_terc4_c;
      locked    <= (state_nxt == ST_LOCKED);
      sym_valid <= s1_valid && (state_nxt == ST_LOCKED);
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock, slip, decode, loss and reset.
module tb_tmds_channel_decoder;

  logic       clk_pixel = 1'b0;
  logic       reset_n;
  logic       raw_valid;
  logic [9:0] raw_word;
  logic       locked;
  logic [3:0] bit_offset;
  logic       sym_valid;
  logic [1:0] sym_type;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic [3:0] terc4;
  logic [7:0] slip_count;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  localparam logic [9:0] T00   = 10'b1101010100;
  localparam logic [9:0] T01   = 10'b0010101011;
  localparam logic [9:0] T10   = 10'b0101010100;
  localparam logic [9:0] T11   = 10'b1010101011;
  localparam logic [9:0] GB    = 10'b0100110011;
  // T00 as seen when the deserializer boundary sits 3 bits late: {T[6:0],T[9:7]}
  localparam logic [9:0] ROT3  = 10'b1010100110;
  localparam logic [9:0] TERC4_TAB [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  tmds_channel_decoder dut (
    .clk_pixel  (clk_pixel),
    .reset_n    (reset_n),
    .raw_valid  (raw_valid),
    .raw_word   (raw_word),
    .locked     (locked),
    .bit_offset (bit_offset),
    .sym_valid  (sym_valid),
    .sym_type   (sym_type),
    .data       (data),
    .ctrl       (ctrl),
    .terc4      (terc4),
    .slip_count (slip_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    raw_valid = 1'b0;
    raw_word  = '0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0b want 0", locked); end
    n_vec++;
    if (bit_offset !== 4'd0) begin n_bad++; $display("FAIL reset_offset: got %0d want 0", bit_offset); end
    n_vec++;
    if (slip_count !== 8'd0) begin n_bad++; $display("FAIL reset_slips: got %0d want 0", slip_count); end
    n_vec++;
    if ({sym_valid, sym_type, data, ctrl, terc4} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_sym: got v=%0b t=%0d d=%h c=%0d n=%0d want all 0",
               sym_valid, sym_type, data, ctrl, terc4);
    end
  endtask

  // First token enters the history word at edge 0, reaches stage 1 at edge 1,
  // and the 8th token is counted at edge 9.
  task automatic test_lock_offset0();
    raw_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      raw_word = T00;
      step();
      if (i == 8) begin
        n_vec++;
        if (locked !== 1'b0) begin n_bad++; $display("FAIL lock_early: got %0b want 0 at cycle 8", locked); end
      end
      if (i == 9) begin
        n_vec++;
        if ({locked, sym_valid, sym_type, ctrl} !== {1'b1, 1'b1, 2'd1, 2'b00}) begin
          n_bad++;
          $display("FAIL lock_at9: got l=%0b v=%0b t=%0d c=%0d want l=1 v=1 t=1 c=0",
                   locked, sym_valid, sym_type, ctrl);
        end
      end
    end
    n_vec++;
    if ({locked, bit_offset, slip_count} !== {1'b1, 4'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL lock_final: got l=%0b off=%0d slips=%0d want 1/0/0", locked, bit_offset, slip_count);
    end
  endtask

  task automatic test_data_ctrl();
    // 0x55 encodes to the balanced word that is also a guard band, so it decodes as GUARD
    logic [9:0] w  [7] = '{10'b0100000000, 10'b1000000000, 10'b0100110011,
                           10'b0111110000, T01, T10, T11};
    logic [1:0] et [7] = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1};
    logic [7:0] ev [7] = '{8'h00, 8'hFF, 8'h00, 8'h10, 8'h01, 8'h02, 8'h03};
    logic [7:0] exp_d;
    logic [1:0] exp_c;
    logic [3:0] exp_t;
    int k;
    raw_valid = 1'b1;
    for (int j = 0; j < 9; j++) begin
      raw_word = (j < 7) ? w[j] : T00;
      step();
      if (j >= 2) begin
        k = j - 2;
        exp_d = (et[k] == 2'd0) ? ev[k] : 8'h00;
        exp_c = (et[k] == 2'd1) ? ev[k][1:0] : 2'b00;
        exp_t = 4'h0;
        n_vec++;
        if ({sym_valid, sym_type, data, ctrl, terc4} !== {1'b1, et[k], exp_d, exp_c, exp_t}) begin
          n_bad++;
          $display("FAIL data_ctrl[%0d]: got v=%0b t=%0d d=%h c=%0d n=%0d want v=1 t=%0d d=%h c=%0d n=0",
                   k, sym_valid, sym_type, data, ctrl, terc4, et[k], exp_d, exp_c);
        end
      end
    end
  endtask

  task automatic test_guard_terc4();
    logic [9:0] w  [17];
    logic [1:0] et [17];
    logic [3:0] en [17];
    int k;
    w[0] = GB; et[0] = 2'd3; en[0] = 4'd0;
    for (int n = 0; n < 16; n++) begin
      w[n+1] = TERC4_TAB[n];
      // nibble 8 shares its code with a guard band, and guard wins
      et[n+1] = (n == 8) ? 2'd3 : 2'd2;
      en[n+1] = (n == 8) ? 4'd0 : 4'(n);
    end
    raw_valid = 1'b1;
    for (int j = 0; j < 19; j++) begin
      raw_word = (j < 17) ? w[j] : T00;
      step();
      if (j >= 2) begin
        k = j - 2;
        n_vec++;
        if ({sym_valid, sym_type, data, ctrl, terc4} !== {1'b1, et[k], 8'h00, 2'b00, en[k]}) begin
          n_bad++;
          $display("FAIL terc4[%0d]: got v=%0b t=%0d d=%h c=%0d n=%0d want v=1 t=%0d d=00 c=0 n=%0d",
                   k, sym_valid, sym_type, data, ctrl, terc4, et[k], en[k]);
        end
      end
    end
  endtask

  task automatic test_valid_gap();
    raw_word = T00;
    for (int i = 0; i < 3; i++) begin
      raw_valid = (i != 0);
      step();
      n_vec++;
      if ({locked, sym_valid} !== {1'b1, (i != 1)}) begin
        n_bad++;
        $display("FAIL valid_gap[%0d]: got l=%0b v=%0b want l=1 v=%0b", i, locked, sym_valid, (i != 1));
      end
    end
  endtask

  task automatic test_slip();
    int slip_at [3] = '{-1, -1, -1};
    int nslip = 0;
    int lock_at = -1;
    logic [7:0] last = 8'd0;
    apply_reset();
    raw_valid = 1'b1;
    raw_word  = ROT3;
    for (int i = 0; i < 8000 && lock_at < 0; i++) begin
      step();
      if (slip_count !== last) begin
        if (nslip < 3) slip_at[nslip] = i;
        nslip++;
        last = slip_count;
      end
      if (locked === 1'b1) lock_at = i;
    end
    n_vec++;
    if (nslip != 3) begin n_bad++; $display("FAIL slip_num: got %0d slips want 3", nslip); end
    for (int s = 0; s < 3; s++) begin
      n_vec++;
      if (slip_at[s] != 2048 * (s + 1)) begin
        n_bad++;
        $display("FAIL slip_time[%0d]: got cycle %0d want %0d", s, slip_at[s], 2048 * (s + 1));
      end
    end
    // slip at 6144, one flushed symbol, then 8 tokens counted at 6146..6153
    n_vec++;
    if (lock_at != 6153) begin n_bad++; $display("FAIL slip_lock_time: got cycle %0d want 6153", lock_at); end
    n_vec++;
    if ({bit_offset, slip_count} !== {4'd3, 8'd3}) begin
      n_bad++;
      $display("FAIL slip_final: got off=%0d slips=%0d want 3/3", bit_offset, slip_count);
    end
  endtask

  // Locked at offset 3; the word straddling the token->data boundary is already
  // non-CTRL, so 4096 non-CTRL symbols are counted at edges 1..4096.
  task automatic test_loss();
    raw_valid = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      raw_word = (i < 4096) ? 10'd0 : ROT3;
      step();
      if (i == 4095) begin
        n_vec++;
        if ({locked, sym_valid, sym_type, data} !== {1'b1, 1'b1, 2'd0, 8'hFE}) begin
          n_bad++;
          $display("FAIL loss_hold: got l=%0b v=%0b t=%0d d=%h want l=1 v=1 t=0 d=fe",
                   locked, sym_valid, sym_type, data);
        end
      end
      if (i == 4096 || i == 4098) begin
        n_vec++;
        if ({locked, sym_valid} !== 2'b00) begin
          n_bad++;
          $display("FAIL loss_drop[%0d]: got l=%0b v=%0b want 0/0", i, locked, sym_valid);
        end
      end
    end
    n_vec++;
    if ({bit_offset, slip_count} !== {4'd3, 8'd3}) begin
      n_bad++;
      $display("FAIL loss_offset: got off=%0d slips=%0d want 3/3", bit_offset, slip_count);
    end
  endtask

  task automatic test_reset_in_search();
    apply_reset();
    raw_valid = 1'b1;
    raw_word  = 10'd0;
    for (int i = 0; i < 12000 && bit_offset !== 4'd5; i++) step();
    n_vec++;
    if ({bit_offset, slip_count, locked} !== {4'd5, 8'd5, 1'b0}) begin
      n_bad++;
      $display("FAIL search_off5: got off=%0d slips=%0d l=%0b want 5/5/0", bit_offset, slip_count, locked);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({locked, bit_offset, sym_valid, sym_type, data, ctrl, terc4, slip_count} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_async: got l=%0b off=%0d v=%0b t=%0d d=%h c=%0d n=%0d slips=%0d want all 0",
               locked, bit_offset, sym_valid, sym_type, data, ctrl, terc4, slip_count);
    end
    step();
    n_vec++;
    if ({locked, bit_offset, sym_valid, sym_type, data, ctrl, terc4, slip_count} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_held: got l=%0b off=%0d v=%0b t=%0d d=%h c=%0d n=%0d slips=%0d want all 0",
               locked, bit_offset, sym_valid, sym_type, data, ctrl, terc4, slip_count);
    end
    reset_n   = 1'b1;
    raw_valid = 1'b0;
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    raw_valid = 1'b0;
    raw_word  = '0;
    test_reset();
    test_lock_offset0();
    test_data_ctrl();
    test_guard_terc4();
    test_valid_gap();
    test_slip();
    test_loss();
    test_reset_in_search();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
